// File: rtl/screen_pkg.sv
// Shared constants and types for the framebuffer scan-out path.
// No logic of its own; no latency or backpressure.
package screen_pkg;

  localparam int SCREEN_W        = 128;
  localparam int SCREEN_H        = 128;
  localparam int PIX_W           = 16;
  localparam int FB_READ_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

endpackage

// File: rtl/screen_pixel_fifo.sv
// Show-ahead FIFO with an occupancy count; a write is visible at the head the next cycle.
// No internal backpressure: the producer must hold a credit, and pushes into a full FIFO without a pop are dropped.
module screen_pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 17
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DW-1:0]              push_dat,
  input  logic                       pop,
  output logic [DW-1:0]              head_dat,
  output logic                       head_vld,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_ok    = pop && (count != '0);
  assign wr_ok    = push && ((count != CW'(DEPTH)) || rd_ok);
  assign head_dat = mem[rd_ptr];
  assign head_vld = (count != '0);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (rd_ok) begin
        rd_ptr <= bump(rd_ptr);
      end
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (!wr_ok && rd_ok) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/screen_framebuffer_scanner.sv
// Raster-order framebuffer reader feeding a valid/ready pixel stream; start->pix_valid is 4 cycles.
// Reads are credit-limited by FIFO occupancy plus in-flight reads, so pix_ready backpressure never overflows the FIFO.
module screen_framebuffer_scanner #(
  parameter int WIDTH        = screen_pkg::SCREEN_W,
  parameter int HEIGHT       = screen_pkg::SCREEN_H,
  parameter int PIX_W        = screen_pkg::PIX_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = screen_pkg::FB_READ_LATENCY
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      frame_done,
  input  logic                      wr_busy,
  output logic                      rd_en,
  output logic [$clog2(WIDTH)-1:0]  rd_addr_x,
  output logic [$clog2(HEIGHT)-1:0] rd_addr_y,
  input  logic [PIX_W-1:0]          mem_data_in,
  input  logic                      mem_valid_in,
  output logic [PIX_W-1:0]          pix_data,
  output logic                      pix_valid,
  output logic                      pix_last,
  input  logic                      pix_ready
);

  import screen_pkg::*;

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

  typedef struct packed {
    logic             last;
    logic [PIX_W-1:0] pixel;
  } pix_entry_t;

  scan_state_t state;
  logic [IW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [IW:0]   credit_used;
  logic          fifo_push;
  logic          fifo_pop;
  pix_entry_t    push_entry;
  pix_entry_t    head;
  logic          head_vld;

  assign credit_used = (IW + 1)'(fifo_count) + (IW + 1)'(inflight);
  assign rd_en       = (state == ST_SCAN) && !wr_busy && (credit_used < (IW + 1)'(FIFO_DEPTH));

  // Beats with nothing outstanding are leftovers from before a reset.
  assign fifo_push = mem_valid_in && (inflight != '0);
  assign fifo_pop  = pix_valid && pix_ready;

  // Reads return in order, so the final beat is the one that empties the in-flight count in DRAIN.
  assign push_entry.last  = (state == ST_DRAIN) && (inflight == IW'(1));
  assign push_entry.pixel = mem_data_in;

  assign pix_valid = head_vld;
  assign pix_data  = head_vld ? head.pixel : '0;
  assign pix_last  = head_vld && head.last;

  screen_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    ($bits(pix_entry_t))
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (push_entry),
    .pop      (fifo_pop),
    .head_dat (head),
    .head_vld (head_vld),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else if (rd_en && !fifo_push) begin
      inflight <= inflight + 1'b1;
    end else if (!rd_en && fifo_push) begin
      inflight <= inflight - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rd_addr_x  <= '0;
      rd_addr_y  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rd_addr_x <= '0;
            rd_addr_y <= '0;
            busy      <= 1'b1;
            state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (rd_en) begin
            if (rd_addr_x == XW'(WIDTH - 1)) begin
              if (rd_addr_y == YW'(HEIGHT - 1)) begin
                state <= ST_DRAIN;
              end else begin
                rd_addr_x <= '0;
                rd_addr_y <= rd_addr_y + 1'b1;
              end
            end else begin
              rd_addr_x <= rd_addr_x + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // Popping the tagged entry means the FIFO and the read pipe are both empty.
          if (fifo_pop && head.last && (inflight == '0)) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
